// File: rtl/mem_arbiter.sv
// Byte-serial arbiter sharing one RAM/IO port between instruction fetch and the load/store buffer.
// Accesses are split into byte transfers; read bytes are reassembled little-endian.
//
// state | meaning
// IDLE  | arbitrate, latch operands of the granted side
// READ  | drive byte addresses, collect bytes one cycle behind the address
// WRITE | drive address/data/strobe, one byte per cycle (stalls on full I/O sink)
// DONE  | owner's done pulse, return to IDLE
module mem_arbiter #(
    parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ls_req,
    input  logic        ls_wr,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    input  logic        flush,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic [2:0]  len;
    logic [23:0] wdata_r;
    logic [31:0] rbuf;
    logic [31:0] rbuf_next;
    logic        own_ls;
    logic        prio_ls;
    logic        io_r;
    logic        mem_wr_r;

    logic        if_ok;
    logic        ls_ok;
    logic        grant_ls;
    logic        grant_if;
    logic [31:0] gnt_addr;
    logic [2:0]  ls_len;
    logic        io_block;

    // Speculative reads are not started during a flush; committed stores still are.
    always_comb begin
        if_ok    = if_req && !flush;
        ls_ok    = ls_req && (!flush || ls_wr);
        grant_ls = ls_ok && (!if_ok || prio_ls);
        grant_if = if_ok && !grant_ls;
        gnt_addr = grant_ls ? ls_addr : if_addr;
        case (ls_size)
            2'd0:    ls_len = 3'd1;
            2'd1:    ls_len = 3'd2;
            default: ls_len = 3'd4;
        endcase
    end

    // Byte cnt-1 arrives on mem_din while cnt is in 1..len.
    always_comb begin
        rbuf_next = rbuf;
        case (cnt)
            3'd1:    rbuf_next[7:0]   = mem_din;
            3'd2:    rbuf_next[15:8]  = mem_din;
            3'd3:    rbuf_next[23:16] = mem_din;
            3'd4:    rbuf_next[31:24] = mem_din;
            default: rbuf_next = rbuf;
        endcase
    end

    assign io_block = (state == WRITE) && io_r && io_buffer_full;
    assign mem_wr   = mem_wr_r && rdy && !io_block;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            len      <= 3'd0;
            wdata_r  <= 24'd0;
            rbuf     <= 32'd0;
            own_ls   <= 1'b0;
            prio_ls  <= 1'b1;
            io_r     <= 1'b0;
            mem_wr_r <= 1'b0;
            mem_a    <= 32'd0;
            mem_dout <= 8'd0;
            if_done  <= 1'b0;
            if_data  <= 32'd0;
            ls_done  <= 1'b0;
            ls_rdata <= 32'd0;
        end else if (rdy) begin
            case (state)
                IDLE: begin
                    if (grant_ls || grant_if) begin
                        cnt     <= 3'd0;
                        rbuf    <= 32'd0;
                        mem_a   <= gnt_addr;
                        own_ls  <= grant_ls;
                        prio_ls <= !grant_ls;
                        io_r    <= (gnt_addr[17:16] == IO_ADDR_HI);
                        len     <= grant_ls ? ls_len : 3'd4;
                        if (grant_ls && ls_wr) begin
                            state    <= WRITE;
                            mem_wr_r <= 1'b1;
                            mem_dout <= ls_wdata[7:0];
                            wdata_r  <= ls_wdata[31:8];
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        if (cnt != 3'd0) begin
                            rbuf <= rbuf_next;
                        end
                        if (cnt == len) begin
                            state <= DONE;
                            if (own_ls) begin
                                ls_done  <= 1'b1;
                                ls_rdata <= rbuf_next;
                            end else begin
                                if_done <= 1'b1;
                                if_data <= rbuf_next;
                            end
                        end else begin
                            cnt <= cnt + 3'd1;
                            if (cnt + 3'd1 < len) begin
                                mem_a <= mem_a + 32'd1;
                            end
                        end
                    end
                end
                WRITE: begin
                    if (!io_block) begin
                        if (cnt + 3'd1 == len) begin
                            state    <= DONE;
                            mem_wr_r <= 1'b0;
                            ls_done  <= 1'b1;
                        end else begin
                            cnt      <= cnt + 3'd1;
                            mem_a    <= mem_a + 32'd1;
                            mem_dout <= wdata_r[7:0];
                            wdata_r  <= {8'h00, wdata_r[23:8]};
                        end
                    end
                end
                DONE: begin
                    if_done <= 1'b0;
                    ls_done <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: byte RAM model, done/data and write scoreboards,
// cycle-exact checks of grant order, stalls, flush and reset.
module tb_mem_arbiter;
    logic        clk;
    logic        rst_n;
    logic        rdy;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        ls_req;
    logic        ls_wr;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic        flush;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    typedef struct packed {logic is_ls; logic [31:0] data;} done_t;
    typedef struct packed {logic [31:0] a; logic [7:0] d;} wr_t;

    done_t exp_q[$];
    wr_t   exp_wr_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  ram [0:65535];
    logic        pl_en;
    logic [15:0] pl_a;
    logic [7:0]  pl_d;
    logic        wr_v;
    logic [31:0] wr_a;
    logic [7:0]  wr_d;

    logic [31:0] a_tr [0:15];
    logic        w_tr [0:15];

    mem_arbiter #(.IO_ADDR_HI(2'b11)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .flush(flush), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
        .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM answers one cycle after the address; writes land on the clock edge.
    always @(posedge clk) begin
        mem_din <= ram[mem_a[15:0]];
        wr_v    <= mem_wr;
        wr_a    <= mem_a;
        wr_d    <= mem_dout;
        if (pl_en)
            ram[pl_a] <= pl_d;
        else if (mem_wr)
            ram[mem_a[15:0]] <= mem_dout;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_tests++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endfunction

    task automatic monitor();
        done_t e;
        wr_t   w;
        forever begin
            @(negedge clk);
            if (wr_v) begin
                chk("wr_expected", 32'(exp_wr_q.size() != 0), 32'd1);
                if (exp_wr_q.size() != 0) begin
                    w = exp_wr_q.pop_front();
                    chk("wr_addr", wr_a, w.a);
                    chk("wr_data", 32'(wr_d), 32'(w.d));
                end
            end
            if (if_done || ls_done) begin
                chk("done_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("done_side", 32'(ls_done), 32'(e.is_ls));
                    chk("done_data", ls_done ? ls_rdata : if_data, e.data);
                end
            end
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en = 1'b1;
        pl_a  = a;
        pl_d  = d;
    endtask

    // One access from cycle 0 (request sampled) until its done pulse; masks select per-cycle inputs.
    task automatic access(input string tag, input bit is_if, input bit wr, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [15:0] iofull_m, input logic [15:0] rdylow_m,
                          input logic [15:0] flush_m, input int exp_done);
        bit seen = 0;
        int n;
        n = is_if ? 4 : (size == 2'd0 ? 1 : (size == 2'd1 ? 2 : 4));
        @(negedge clk);
        if (is_if) begin
            if_req  = 1'b1;
            if_addr = addr;
        end else begin
            ls_req   = 1'b1;
            ls_wr    = wr;
            ls_size  = size;
            ls_addr  = addr;
            ls_wdata = wdata;
        end
        io_buffer_full = iofull_m[0];
        rdy            = !rdylow_m[0];
        flush          = flush_m[0];
        for (int c = 1; c <= 15 && !seen; c++) begin
            @(negedge clk);
            io_buffer_full = iofull_m[c];
            rdy            = !rdylow_m[c];
            flush          = flush_m[c];
            #1;
            a_tr[c] = mem_a;
            w_tr[c] = mem_wr;
            if (iofull_m == 16'd0 && rdylow_m == 16'd0 && flush_m == 16'd0 && c <= n) begin
                chk($sformatf("%s_a_c%0d", tag, c), mem_a, addr + 32'(c - 1));
                chk($sformatf("%s_wr_c%0d", tag, c), 32'(mem_wr), 32'(wr));
            end
            chk($sformatf("%s_done_c%0d", tag, c), 32'(is_if ? if_done : ls_done), 32'(c == exp_done));
            if (if_done || ls_done) seen = 1;
        end
        if_req         = 1'b0;
        ls_req         = 1'b0;
        io_buffer_full = 1'b0;
        rdy            = 1'b1;
        flush          = 1'b0;
    endtask

    // Concurrent byte load and word fetch; checks which finishes when.
    task automatic pair(input string tag, input logic [31:0] la, input logic [31:0] fa,
                        input int exp_ls_cy, input int exp_if_cy, input logic [31:0] exp_ls);
        int ls_cy = 0;
        int if_cy = 0;
        @(negedge clk);
        ls_req  = 1'b1;
        ls_wr   = 1'b0;
        ls_size = 2'd0;
        ls_addr = la;
        if_req  = 1'b1;
        if_addr = fa;
        for (int c = 1; c <= 24 && (ls_req || if_req); c++) begin
            @(negedge clk);
            #1;
            if (ls_done) begin ls_req = 1'b0; ls_cy = c; end
            if (if_done) begin if_req = 1'b0; if_cy = c; end
        end
        ls_req = 1'b0;
        if_req = 1'b0;
        chk($sformatf("%s_ls_cycle", tag), 32'(ls_cy), 32'(exp_ls_cy));
        chk($sformatf("%s_if_cycle", tag), 32'(if_cy), 32'(exp_if_cy));
        chk($sformatf("%s_ls_hold", tag), ls_rdata, exp_ls);
    endtask

    initial begin
        rst_n = 1'b0; rdy = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b0; if_addr = 32'd0;
        ls_req = 1'b0; ls_wr = 1'b0; ls_size = 2'd0; ls_addr = 32'd0; ls_wdata = 32'd0;
        pl_en = 1'b0; pl_a = 16'd0; pl_d = 8'd0;
        fork monitor(); join_none

        poke(16'h1000, 8'h13); poke(16'h1001, 8'h05); poke(16'h1002, 8'h00); poke(16'h1003, 8'h00);
        poke(16'h0020, 8'h80); poke(16'h0021, 8'h7F);
        poke(16'h0040, 8'h11); poke(16'h0041, 8'h22); poke(16'h0042, 8'h33); poke(16'h0043, 8'h44);
        poke(16'hFFFE, 8'hAA); poke(16'hFFFF, 8'hBB); poke(16'h0000, 8'hCC); poke(16'h0001, 8'hDD);
        @(negedge clk);
        pl_en = 1'b0;
        #1;
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_mem_dout", 32'(mem_dout), 32'd0);
        chk("rst_if_done", 32'(if_done), 32'd0);
        chk("rst_ls_done", 32'(ls_done), 32'd0);
        chk("rst_if_data", if_data, 32'd0);
        chk("rst_ls_rdata", ls_rdata, 32'd0);
        rst_n = 1'b1;

        // Priority: LS first after reset, then alternation; second pair also wraps the fetch address.
        exp_q.push_back({1'b1, 32'h0000_0080}); exp_q.push_back({1'b0, 32'h0000_0513});
        pair("prio1", 32'h20, 32'h1000, 3, 10, 32'h0000_0080);
        exp_q.push_back({1'b1, 32'h0000_007F}); exp_q.push_back({1'b0, 32'hDDCC_BBAA});
        pair("prio2", 32'h21, 32'hFFFF_FFFE, 3, 10, 32'h0000_007F);

        exp_q.push_back({1'b0, 32'h0000_0513});
        access("fetch", 1, 0, 2'd0, 32'h1000, 32'd0, 16'h0, 16'h0, 16'h0, 6);
        exp_q.push_back({1'b1, 32'h4433_2211});
        access("ldw", 0, 0, 2'd2, 32'h40, 32'd0, 16'h0, 16'h0, 16'h0, 6);

        // I/O half store held off by a full sink in cycles 1-3.
        exp_wr_q.push_back({32'h30000, 8'hEF}); exp_wr_q.push_back({32'h30001, 8'hBE});
        exp_q.push_back({1'b1, 32'h4433_2211});
        access("io_st", 0, 1, 2'd1, 32'h30000, 32'h0000_BEEF, 16'h000E, 16'h0, 16'h0, 6);
        chk("io_wr_c1", 32'(w_tr[1]), 32'd0);
        chk("io_wr_c3", 32'(w_tr[3]), 32'd0);
        chk("io_wr_c4", 32'(w_tr[4]), 32'd1);
        chk("io_a_c4", a_tr[4], 32'h30000);
        chk("io_wr_c5", 32'(w_tr[5]), 32'd1);
        chk("io_a_c5", a_tr[5], 32'h30001);

        // Store under flush outside I/O space: full sink is ignored, all bytes written.
        exp_wr_q.push_back({32'h100, 8'hAA}); exp_wr_q.push_back({32'h101, 8'hBB});
        exp_wr_q.push_back({32'h102, 8'hCC}); exp_wr_q.push_back({32'h103, 8'hDD});
        exp_q.push_back({1'b1, 32'h4433_2211});
        access("fl_st", 0, 1, 2'd2, 32'h100, 32'hDDCC_BBAA, 16'hFFFF, 16'h0, 16'h003F, 5);

        // Word load flushed in cycle 3, then a byte load issued in cycle 4.
        @(negedge clk);
        ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd2; ls_addr = 32'h40;
        repeat (2) begin
            @(negedge clk); #1;
            chk("abort_early_done", 32'(ls_done), 32'd0);
        end
        @(negedge clk);
        flush = 1'b1; ls_req = 1'b0;
        #1;
        chk("abort_a_c3", mem_a, 32'h42);
        @(negedge clk);
        flush = 1'b0; ls_req = 1'b1; ls_size = 2'd0; ls_addr = 32'h20;
        exp_q.push_back({1'b1, 32'h0000_0080});
        #1;
        chk("abort_a_hold", mem_a, 32'h42);
        chk("abort_no_done", 32'(ls_done), 32'd0);
        for (int c = 5; c <= 9 && ls_req; c++) begin
            @(negedge clk); #1;
            if (c == 5) chk("after_abort_a", mem_a, 32'h20);
            chk($sformatf("after_abort_done_c%0d", c), 32'(ls_done), 32'(c == 7));
            if (ls_done) ls_req = 1'b0;
        end
        ls_req = 1'b0;

        // rdy low freezes a store for two cycles and a byte load for two cycles.
        exp_wr_q.push_back({32'h200, 8'h11}); exp_wr_q.push_back({32'h201, 8'h22});
        exp_wr_q.push_back({32'h202, 8'h33}); exp_wr_q.push_back({32'h203, 8'h44});
        exp_q.push_back({1'b1, 32'h0000_0080});
        access("rdy_st", 0, 1, 2'd2, 32'h200, 32'h4433_2211, 16'h0, 16'h000C, 16'h0, 7);
        chk("rdy_wr_c2", 32'(w_tr[2]), 32'd0);
        chk("rdy_wr_c3", 32'(w_tr[3]), 32'd0);
        chk("rdy_a_c3", a_tr[3], 32'h201);
        chk("rdy_wr_c4", 32'(w_tr[4]), 32'd1);
        exp_q.push_back({1'b1, 32'h0000_007F});
        access("rdy_ld", 0, 0, 2'd0, 32'h21, 32'd0, 16'h0, 16'h0006, 16'h0, 5);

        // Fetch is ignored while flush is high in IDLE.
        exp_q.push_back({1'b0, 32'h0000_0513});
        access("fl_if", 1, 0, 2'd0, 32'h1000, 32'd0, 16'h0, 16'h0, 16'h0001, 7);

        // Reset in the middle of a word store.
        @(negedge clk);
        ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd2; ls_addr = 32'h300; ls_wdata = 32'h0A0B_0C0D;
        exp_wr_q.push_back({32'h300, 8'h0D});
        @(negedge clk); #1;
        chk("mid_wr_c1", 32'(mem_wr), 32'd1);
        @(negedge clk); #1;
        chk("mid_a_c2", mem_a, 32'h301);
        rst_n = 1'b0;
        #1;
        chk("arst_mem_wr", 32'(mem_wr), 32'd0);
        chk("arst_mem_a", mem_a, 32'd0);
        chk("arst_mem_dout", 32'(mem_dout), 32'd0);
        chk("arst_ls_rdata", ls_rdata, 32'd0);
        chk("arst_if_data", if_data, 32'd0);
        chk("arst_ls_done", 32'(ls_done), 32'd0);
        chk("arst_if_done", 32'(if_done), 32'd0);
        ls_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back({1'b1, 32'h0000_0080}); exp_q.push_back({1'b0, 32'h0000_0513});
        pair("post_rst", 32'h20, 32'h1000, 3, 10, 32'h0000_0080);

        repeat (3) @(negedge clk);
        #1;
        chk("done_q_empty", 32'(exp_q.size()), 32'd0);
        chk("wr_q_empty", 32'(exp_wr_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
